// File: rtl/mem_access_stage.sv
// Memory access stage: turns the execute unit's memory request into a data-bus
// valid/ready transaction and returns the extended load result or access fault.
module mem_access_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter int unsigned CNT_W          = 9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        req_load,
    input  logic        req_store,
    input  logic [31:0] req_addr,
    input  logic [3:0]  req_mask,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata,
    input  logic        bus_err,
    output logic        busy,
    output logic        resp_valid,
    output logic [31:0] load_data,
    output logic        load_fault,
    output logic        store_fault
);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, DRAIN} state_t;

    state_t            state, state_nxt;
    logic              accept;
    logic              tmo;
    logic [CNT_W-1:0]  cnt;

    logic              lat_load;
    logic [31:0]       lat_addr;
    logic [3:0]        lat_mask;
    logic [31:0]       lat_wdata;
    logic [1:0]        lat_size;
    logic              lat_uns;

    logic [31:0]       rsp_data;
    logic              rsp_fault;

    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [31:0]       ext_data;

    always_comb begin
        accept = !rst && (state == IDLE) && (req_load || req_store) && !flush;
        tmo    = (TIMEOUT_CYCLES != 0) && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    end

    // flush wins over a same-cycle rvalid/timeout in WAIT; that response is
    // the one a drain would have waited for, so skip DRAIN entirely.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (accept) state_nxt = REQ;
            REQ: begin
                if (flush)        state_nxt = bus_gnt ? DRAIN : IDLE;
                else if (bus_gnt) state_nxt = WAIT;
            end
            WAIT: begin
                if (flush)                    state_nxt = (bus_rvalid || tmo) ? IDLE : DRAIN;
                else if (bus_rvalid || tmo)   state_nxt = DONE;
            end
            DONE:  state_nxt = IDLE;
            DRAIN: if (bus_rvalid || tmo) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            lat_load  <= 1'b0;
            lat_addr  <= '0;
            lat_mask  <= '0;
            lat_wdata <= '0;
            lat_size  <= '0;
            lat_uns   <= 1'b0;
            rsp_data  <= '0;
            rsp_fault <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                lat_load  <= req_load;
                lat_addr  <= req_addr;
                lat_mask  <= req_mask;
                lat_wdata <= req_wdata;
                lat_size  <= req_size;
                lat_uns   <= req_unsigned;
            end
            // DRAIN keeps counting from WAIT so a lost response still times out
            if (state == REQ && bus_gnt)
                cnt <= '0;
            else if (state == WAIT || state == DRAIN)
                cnt <= cnt + 1'b1;
            if (state == WAIT && !flush) begin
                if (bus_rvalid) begin
                    rsp_data  <= bus_rdata;
                    rsp_fault <= bus_err;
                end else if (tmo) begin
                    rsp_data  <= '0;
                    rsp_fault <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        byte_sel = 8'(rsp_data >> {lat_addr[1:0], 3'b000});
        half_sel = lat_addr[1] ? rsp_data[31:16] : rsp_data[15:0];
        case (lat_size)
            2'd0:    ext_data = {{24{~lat_uns & byte_sel[7]}}, byte_sel};
            2'd1:    ext_data = {{16{~lat_uns & half_sel[15]}}, half_sel};
            default: ext_data = rsp_data;
        endcase
    end

    always_comb begin
        bus_req     = (state == REQ);
        bus_we      = bus_req & ~lat_load;
        bus_addr    = bus_req ? {lat_addr[31:2], 2'b00} : '0;
        bus_be      = bus_req ? lat_mask : '0;
        bus_wdata   = bus_req ? lat_wdata : '0;
        busy        = (state inside {REQ, WAIT, DRAIN}) || accept;
        resp_valid  = (state == DONE);
        load_fault  = resp_valid & rsp_fault & lat_load;
        store_fault = resp_valid & rsp_fault & ~lat_load;
        load_data   = (resp_valid && lat_load && !rsp_fault) ? ext_data : '0;
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: the stimulus side plays both the
// execute unit and the bus slave, the monitor checks every completed access.
module tb_mem_access_stage;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst, flush;
    logic        req_load, req_store, req_unsigned;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_mask;
    logic [1:0]  req_size;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_be;
    logic        bus_gnt, bus_rvalid, bus_err;
    logic        busy, resp_valid, load_fault, store_fault;
    logic [31:0] load_data;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int          cyc;
        logic [31:0] data;
        logic        lf;
        logic        sf;
    } exp_t;

    exp_t exp_q[$];

    mem_access_stage #(.TIMEOUT_CYCLES(TMO), .CNT_W(3)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_load(req_load), .req_store(req_store), .req_addr(req_addr),
        .req_mask(req_mask), .req_wdata(req_wdata), .req_size(req_size),
        .req_unsigned(req_unsigned),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid),
        .bus_rdata(bus_rdata), .bus_err(bus_err),
        .busy(busy), .resp_valid(resp_valid), .load_data(load_data),
        .load_fault(load_fault), .store_fault(store_fault)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk1(input string name, input logic act, input logic want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %b want %b (cycle %0d)", name, act, want, cyc);
        end
    endfunction

    function automatic void chk32(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, want, cyc);
        end
    endfunction

    // Load result straight from the extraction rules, using integer arithmetic.
    function automatic logic [31:0] ref_load(input logic [31:0] rdata, input logic [31:0] addr,
                                             input logic [1:0] size, input bit uns);
        longint v;
        case (size)
            2'd0: begin
                v = longint'((rdata >> (8 * addr[1:0])) & 32'hFF);
                if (!uns && v >= 128) v = v - 256;
            end
            2'd1: begin
                v = longint'((rdata >> (16 * addr[1])) & 32'hFFFF);
                if (!uns && v >= 32768) v = v - 65536;
            end
            default: v = longint'(rdata);
        endcase
        return 32'(v);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_bus(input bit ld, input logic [31:0] addr, input logic [3:0] mask,
                             input logic [31:0] wdata);
        chk1("bus_req_high", bus_req, 1'b1);
        chk1("bus_we", bus_we, !ld);
        chk32("bus_addr", bus_addr, {addr[31:2], 2'b00});
        chk32("bus_be", 32'(bus_be), 32'(mask));
        if (!ld) chk32("bus_wdata", bus_wdata, wdata);
    endtask

    // fmode: 0 none, 1 flush in REQ without gnt, 2 flush with gnt, 3 flush in WAIT at fidx.
    // rd is the WAIT index of rvalid; rd >= TMO means the slave never answers.
    task automatic run_access(input bit ld, input logic [31:0] addr, input logic [1:0] size,
                              input bit uns, input logic [3:0] mask, input logic [31:0] wdata,
                              input logic [31:0] rdata, input bit err,
                              input int gd, input int rd, input int fmode, input int fidx);
        exp_t e;
        bit   timed_out;
        int   last;
        req_load = ld; req_store = !ld; req_addr = addr; req_size = size;
        req_unsigned = uns; req_mask = mask; req_wdata = wdata;
        @(negedge clk);
        chk1("busy_accept", busy, 1'b1);
        step();
        req_load = 1'b0; req_store = 1'b0; req_addr = $urandom; req_wdata = $urandom;
        req_mask = 4'($urandom); req_size = 2'($urandom); req_unsigned = 1'($urandom);
        if (fmode == 1) begin
            flush = 1'b1;
            @(negedge clk);
            check_bus(ld, addr, mask, wdata);
            step();
            flush = 1'b0;
            @(negedge clk);
            chk1("req_flush_bus_req", bus_req, 1'b0);
            chk1("req_flush_busy", busy, 1'b0);
            step();
            return;
        end
        for (int i = 0; i < gd; i++) begin
            @(negedge clk);
            check_bus(ld, addr, mask, wdata);
            step();
        end
        bus_gnt = 1'b1;
        if (fmode == 2) flush = 1'b1;
        @(negedge clk);
        check_bus(ld, addr, mask, wdata);
        step();
        bus_gnt = 1'b0;
        flush   = 1'b0;
        timed_out = (fmode == 0) && (rd >= TMO);
        last      = timed_out ? TMO - 1 : rd;
        if (fmode == 0) begin
            e.cyc  = cyc + last + 1;
            e.lf   = (err || timed_out) && ld;
            e.sf   = (err || timed_out) && !ld;
            e.data = (ld && !err && !timed_out) ? ref_load(rdata, addr, size, uns) : 32'd0;
            exp_q.push_back(e);
        end
        for (int i = 0; i <= last; i++) begin
            bus_rvalid = !timed_out && (i == rd);
            bus_rdata  = bus_rvalid ? rdata : $urandom;
            bus_err    = bus_rvalid ? err : 1'($urandom);
            flush      = (fmode == 3) && (i == fidx);
            @(negedge clk);
            chk1("busy_wait", busy, 1'b1);
            chk1("bus_req_wait", bus_req, 1'b0);
            step();
        end
        bus_rvalid = 1'b0;
        bus_err    = 1'b0;
        flush      = 1'b0;
        @(negedge clk);
        chk1("busy_after", busy, 1'b0);
        if (fmode != 0) chk1("no_resp_killed", resp_valid, 1'b0);
        step();
        if (timed_out) begin
            bus_rvalid = 1'b1;
            bus_rdata  = $urandom;
            @(negedge clk);
            chk1("late_rvalid_busy", busy, 1'b0);
            step();
            bus_rvalid = 1'b0;
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && resp_valid) begin
                chk1("resp_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk32("resp_cycle", 32'(cyc), 32'(e.cyc));
                    chk32("load_data", load_data, e.data);
                    chk1("load_fault", load_fault, e.lf);
                    chk1("store_fault", store_fault, e.sf);
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    initial begin : stim
        bit          ld, uns, er;
        logic [31:0] a, wd, rdv;
        logic [1:0]  sz;
        logic [3:0]  mk;
        int          gd, rd, fm, fi, r;

        rst = 1'b1; flush = 1'b0; req_load = 1'b0; req_store = 1'b0; req_addr = '0;
        req_mask = '0; req_wdata = '0; req_size = '0; req_unsigned = 1'b0;
        bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0; bus_err = 1'b0;
        repeat (3) step();
        @(negedge clk);
        chk1("rst_bus_req", bus_req, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_resp_valid", resp_valid, 1'b0);
        chk32("rst_load_data", load_data, 32'd0);
        chk32("rst_bus_addr", bus_addr, 32'd0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk1("idle_busy", busy, 1'b0);
        chk1("idle_bus_req", bus_req, 1'b0);
        chk1("idle_faults", load_fault | store_fault, 1'b0);
        step();

        // LB sign-extended, minimum latency
        run_access(1, 32'h1003, 2'd0, 0, 4'h8, 32'h0, 32'h8000_0000, 0, 0, 0, 0, 0);
        step();
        // LHU / LH upper half
        run_access(1, 32'h2002, 2'd1, 1, 4'hC, 32'h0, 32'hBEEF_1234, 0, 0, 0, 0, 0);
        step();
        run_access(1, 32'h2002, 2'd1, 0, 4'hC, 32'h0, 32'hBEEF_1234, 0, 0, 1, 0, 0);
        step();
        // SW with grant held off for 5 cycles
        run_access(0, 32'h10, 2'd2, 0, 4'hF, 32'hDEAD_BEEF, 32'h1234_5678, 0, 5, 1, 0, 0);
        step();
        // load flushed in WAIT, response 3 cycles later
        run_access(1, 32'h40, 2'd2, 0, 4'hF, 32'h0, 32'hCAFE_F00D, 0, 0, 3, 3, 0);
        step();
        // load with no response: timeout fault
        run_access(1, 32'h44, 2'd2, 0, 4'hF, 32'h0, 32'h0, 0, 0, 9, 0, 0);
        step();
        // store answered with bus_err
        run_access(0, 32'h48, 2'd2, 0, 4'hF, 32'h1111_2222, 32'hFFFF_FFFF, 1, 1, 2, 0, 0);
        step();

        // flush in IDLE blocks the accept
        req_load = 1'b1; flush = 1'b1; req_addr = 32'h80;
        @(negedge clk);
        chk1("flush_idle_busy", busy, 1'b0);
        step();
        req_load = 1'b0; flush = 1'b0;
        @(negedge clk);
        chk1("flush_idle_bus_req", bus_req, 1'b0);
        step();

        // reset while the request is on the bus
        req_store = 1'b1; req_addr = 32'h90; req_mask = 4'h3; req_wdata = 32'h5555_AAAA;
        step();
        req_store = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk1("pre_rst_bus_req", bus_req, 1'b1);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk1("rst_in_req_bus_req", bus_req, 1'b0);
        chk1("rst_in_req_busy", busy, 1'b0);
        step();

        for (int n = 0; n < 80; n++) begin
            ld  = 1'($urandom_range(0, 1));
            a   = $urandom;
            sz  = 2'($urandom_range(0, 2));
            uns = 1'($urandom_range(0, 1));
            mk  = 4'($urandom);
            wd  = $urandom;
            rdv = $urandom;
            er  = ($urandom_range(0, 9) == 0);
            gd  = $urandom_range(0, 3);
            r   = $urandom_range(0, 99);
            fm  = (r < 70) ? 0 : (r < 80) ? 1 : (r < 88) ? 2 : 3;
            rd  = (fm == 0) ? $urandom_range(0, 5) : $urandom_range(0, 3);
            fi  = (fm == 3) ? $urandom_range(0, rd) : 0;
            run_access(ld, a, sz, uns, mk, wd, rdv, er, gd, rd, fm, fi);
            repeat ($urandom_range(0, 2)) step();
        end

        repeat (4) step();
        chk32("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
